// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the clock divider controller.
package clkdiv_pkg;

   typedef enum logic [1:0] {
      CLK_STOPPED = 2'd0,
      CLK_RUN     = 2'd1,
      CLK_DRAIN   = 2'd2
   } ClkState_t;

   // Smallest ratio that still yields a divided clock with a high phase.
   localparam int unsigned CLKDIV_MIN_DIV = 2;

endpackage

// File: rtl/clkdiv_counter.sv
// Period counter and registered divided-clock / tick generation.
// A period starts with tick and clk high together; clk is high for
// floor(div/2) of the div cycles. 'halt' turns the current wrap into a
// clean stop instead of the start of a new period.
module clkdiv_counter #(
   parameter int unsigned DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             start,
   input  logic             halt,
   input  logic [DIV_W-1:0] div,
   output logic             div_clk,
   output logic             tick,
   output logic             wrap
);

   logic [DIV_W-1:0] ctr;
   logic [DIV_W-1:0] ctr_inc;
   logic [DIV_W-1:0] half;

   assign ctr_inc = ctr + 1'b1;
   assign half    = div >> 1;
   assign wrap    = run && (ctr == (div - 1'b1));

   // Advance the period counter and derive clk/tick for the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr     <= '0;
         div_clk <= 1'b0;
         tick    <= 1'b0;
      end else if (start) begin
         ctr     <= '0;
         div_clk <= 1'b1;
         tick    <= 1'b1;
      end else if (wrap) begin
         ctr     <= '0;
         div_clk <= !halt;
         tick    <= !halt;
      end else if (run) begin
         ctr     <= ctr_inc;
         div_clk <= (ctr_inc < half);
         tick    <= 1'b0;
      end else begin
         ctr     <= '0;
         div_clk <= 1'b0;
         tick    <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable clock divider: start/stop
// sequencing, ratio handshake and period-boundary ratio updates.
// Optional status outputs (o_cur_div, o_period_cnt) are built when
// CLKDIV_CTRL_STATUS_EN is defined.
module clk_div_ctrl
   import clkdiv_pkg::*;
#(
   parameter int unsigned DIV_W       = 4,
   parameter int unsigned DEFAULT_DIV = 6
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_enable,
   input  logic             i_cfg_valid,
   output logic             o_cfg_ready,
   input  logic [DIV_W-1:0] i_cfg_div,
   output logic             o_cfg_err,
   output logic             o_clk,
   output logic             o_tick,
   output logic             o_running
`ifdef CLKDIV_CTRL_STATUS_EN
   ,
   output logic [DIV_W-1:0] o_cur_div,
   output logic [15:0]      o_period_cnt
`endif
);

   ClkState_t        state;
   ClkState_t        state_nxt;
   logic [DIV_W-1:0] cur_div;
   logic [DIV_W-1:0] pend_div;
   logic             pend_valid;
   logic             wrap;
   logic             xfer;
   logic             legal;
   logic             start;
   logic             halt;

   assign o_cfg_ready = (state == CLK_STOPPED) || !pend_valid;
   assign o_running   = (state != CLK_STOPPED);
   assign xfer        = i_cfg_valid && o_cfg_ready;
   assign legal       = (i_cfg_div >= DIV_W'(CLKDIV_MIN_DIV));
   assign start       = (state == CLK_STOPPED) && i_enable;
   assign halt        = (state == CLK_DRAIN) && !i_enable;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= CLK_STOPPED;
      else       state <= state_nxt;
   end

   // Next-state logic; DRAIN only leaves to STOPPED on a period boundary.
   always_comb begin
      state_nxt = state;
      case (state)
         CLK_STOPPED: if (i_enable) state_nxt = CLK_RUN;
         CLK_RUN:     if (!i_enable) state_nxt = CLK_DRAIN;
         CLK_DRAIN: begin
            if (i_enable)  state_nxt = CLK_RUN;
            else if (wrap) state_nxt = CLK_STOPPED;
         end
         default:     state_nxt = CLK_STOPPED;
      endcase
   end

   // Ratio handshake: immediate when stopped, otherwise deferred to the
   // next wrap. A transfer on the wrap cycle itself takes effect at that
   // wrap (ready is only high then if nothing is pending).
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cur_div    <= DIV_W'(DEFAULT_DIV);
         pend_div   <= '0;
         pend_valid <= 1'b0;
         o_cfg_err  <= 1'b0;
      end else begin
         o_cfg_err <= xfer && !legal;
         if (state == CLK_STOPPED) begin
            pend_valid <= 1'b0;
            if (xfer && legal) cur_div <= i_cfg_div;
         end else if (wrap) begin
            if (pend_valid) begin
               cur_div    <= pend_div;
               pend_valid <= 1'b0;
            end else if (xfer && legal) begin
               cur_div <= i_cfg_div;
            end
         end else if (xfer && legal) begin
            pend_div   <= i_cfg_div;
            pend_valid <= 1'b1;
         end
      end
   end

   clkdiv_counter #(
      .DIV_W (DIV_W)
   ) u_counter (
      .clk     (i_clk),
      .rst     (i_rst),
      .run     (o_running),
      .start   (start),
      .halt    (halt),
      .div     (cur_div),
      .div_clk (o_clk),
      .tick    (o_tick),
      .wrap    (wrap)
   );

`ifdef CLKDIV_CTRL_STATUS_EN
   logic [15:0] period_cnt;

   // Count completed periods; holds while stopped since no wraps occur.
   always_ff @(posedge i_clk) begin
      if (i_rst)     period_cnt <= '0;
      else if (wrap) period_cnt <= period_cnt + 16'd1;
   end

   assign o_cur_div    = cur_div;
   assign o_period_cnt = period_cnt;
`else
   // Status outputs and period counter are not built.
`endif

endmodule
